// File: rtl/pit_timer.sv
// Programmable interval timer: a prescaler down-counter whose borrow-out clocks a
// divider down-counter; divider underflow raises a one-cycle irq and a sticky pending flag.
module pit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resl,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_pre,
  input  logic             wr_div,
  input  logic             rd_sel,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] dout,
  output logic             tick,
  output logic             irq,
  output logic             irq_pend
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pre_reg_r;
  logic [WIDTH-1:0] pre_cnt_r;
  logic [WIDTH-1:0] div_reg_r;
  logic [WIDTH-1:0] div_cnt_r;
  logic             irq_r;
  logic             irq_pend_r;

  logic             active_s;
  logic             tick_s;
  logic             underflow_s;
  logic [WIDTH-1:0] pre_cnt_nxt_s;
  logic [WIDTH-1:0] div_cnt_nxt_s;
  logic             irq_pend_nxt_s;
  logic [WIDTH-1:0] dout_s;

  // Borrow chain, counter next-state and interrupt flag next-state.
  always_comb begin
    active_s       = 1'b0;
    tick_s         = 1'b0;
    underflow_s    = 1'b0;
    pre_cnt_nxt_s  = pre_cnt_r;
    div_cnt_nxt_s  = div_cnt_r;
    irq_pend_nxt_s = irq_pend_r;

    active_s = (div_reg_r != ZERO);
    tick_s   = active_s & (pre_cnt_r == ZERO);
    // A divider load in the same cycle swallows the underflow and its irq.
    underflow_s = tick_s & ~wr_div & (div_cnt_r == ZERO);

    if (wr_pre) begin
      pre_cnt_nxt_s = din;
    end else if (active_s) begin
      if (tick_s) begin
        pre_cnt_nxt_s = pre_reg_r;
      end else begin
        pre_cnt_nxt_s = pre_cnt_r - ONE;
      end
    end else begin
      pre_cnt_nxt_s = pre_cnt_r;
    end

    if (wr_div) begin
      div_cnt_nxt_s = din;
    end else if (tick_s) begin
      if (underflow_s) begin
        div_cnt_nxt_s = div_reg_r;
      end else begin
        div_cnt_nxt_s = div_cnt_r - ONE;
      end
    end else begin
      div_cnt_nxt_s = div_cnt_r;
    end

    irq_pend_nxt_s = underflow_s | (irq_pend_r & ~irq_ack);
  end

  // Readback mux: shows counts as they stand before this edge's update.
  always_comb begin
    dout_s = pre_cnt_r;
    if (rd_sel) begin
      dout_s = div_cnt_r;
    end else begin
      dout_s = pre_cnt_r;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      pre_reg_r  <= ZERO;
      pre_cnt_r  <= ZERO;
      div_reg_r  <= ZERO;
      div_cnt_r  <= ZERO;
      irq_r      <= 1'b0;
      irq_pend_r <= 1'b0;
    end else begin
      if (wr_pre) begin
        pre_reg_r <= din;
      end else begin
        pre_reg_r <= pre_reg_r;
      end
      if (wr_div) begin
        div_reg_r <= din;
      end else begin
        div_reg_r <= div_reg_r;
      end
      pre_cnt_r  <= pre_cnt_nxt_s;
      div_cnt_r  <= div_cnt_nxt_s;
      irq_r      <= underflow_s;
      irq_pend_r <= irq_pend_nxt_s;
    end
  end

  assign dout     = dout_s;
  assign tick     = tick_s;
  assign irq      = irq_r;
  assign irq_pend = irq_pend_r;

endmodule

// File: tb/tb_pit_timer.sv
// Scoreboard bench for pit_timer: stimulus pushes expected outputs from an
// elapsed-count reference model; a negedge monitor pops and compares.
module tb_pit_timer;

  logic        clk = 1'b0;
  logic        resl = 1'b0;
  logic [15:0] din = 16'd0;
  logic        wr_pre = 1'b0;
  logic        wr_div = 1'b0;
  logic        rd_sel = 1'b0;
  logic        irq_ack = 1'b0;
  logic [15:0] dout;
  logic        tick;
  logic        irq;
  logic        irq_pend;

  pit_timer #(.WIDTH(16)) dut (
    .clk(clk), .resl(resl), .din(din), .wr_pre(wr_pre), .wr_div(wr_div),
    .rd_sel(rd_sel), .irq_ack(irq_ack), .dout(dout), .tick(tick),
    .irq(irq), .irq_pend(irq_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dout;
    logic        tick;
    logic        irq;
    logic        pend;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_period = 0;
  int   ncyc = 0;
  int   last_irq = -1;

  // Reference model: reload values plus clocks elapsed since each counter's last reload.
  int   m_pr = 0, m_pk = 0, m_dr = 0, m_dk = 0;
  logic m_irq = 1'b0, m_pend = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, ncyc, act, exp);
    end
  endtask

  function automatic logic uf_now();
    return (m_dr != 0) && (m_pk == m_pr) && (m_dk == m_dr);
  endfunction

  task automatic cyc(input logic r, input logic wp, input logic wd, input logic rs,
                     input logic ack, input logic [15:0] d);
    exp_t e;
    logic act, tk, uf;
    @(posedge clk);
    #1;
    resl = r; wr_pre = wp; wr_div = wd; rd_sel = rs; irq_ack = ack; din = d;
    if (!r) begin
      m_pr = 0; m_pk = 0; m_dr = 0; m_dk = 0; m_irq = 1'b0; m_pend = 1'b0;
    end
    act = (m_dr != 0);
    tk  = act && (m_pk == m_pr);
    e.dout = rs ? 16'(m_dr - m_dk) : 16'(m_pr - m_pk);
    e.tick = tk;
    e.irq  = m_irq;
    e.pend = m_pend;
    q.push_back(e);
    if (r) begin
      uf = tk && !wd && (m_dk == m_dr);
      if (wp) begin m_pr = int'(d); m_pk = 0; end
      else if (act) m_pk = tk ? 0 : m_pk + 1;
      if (wd) begin m_dr = int'(d); m_dk = 0; end
      else if (tk) m_dk = uf ? 0 : m_dk + 1;
      m_pend = uf | (m_pend & ~ack);
      m_irq  = uf;
    end
  endtask

  task automatic idle(input int n, input logic allow_ack);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
          allow_ack && ($urandom_range(0, 3) == 0), 16'($urandom));
  endtask

  // Monitor: compare every presented cycle and the spacing of irq pulses.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dout", int'(dout), int'(e.dout));
      chk("tick", int'(tick), int'(e.tick));
      chk("irq", int'(irq), int'(e.irq));
      chk("irq_pend", int'(irq_pend), int'(e.pend));
    end
    if (exp_period == 0) begin
      last_irq = -1;
    end else if (irq === 1'b1) begin
      if (last_irq >= 0) chk("irq_period", ncyc - last_irq, exp_period);
      last_irq = ncyc;
    end
  end

  initial begin
    logic found;

    // Reset held with random strobes.
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));

    // pre=1, div=2: 6-clock interrupt period.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    exp_period = 6;
    idle(30, 1'b1);
    exp_period = 0;

    // pre=0, div=3: tick every clock, 4-clock period, divider readback.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3);
    exp_period = 4;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    exp_period = 0;

    // pre=4, div=1; stop mid-period, hold, then restart.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    idle(13, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    idle(15, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
    idle(15, 1'b0);

    // wr_div colliding with an underflow cycle, then irq_ack colliding with irq rise.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (uf_now()) begin
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
        found = 1'b1;
      end else begin
        idle(1, 1'b0);
      end
    end
    chk("div_collision_reached", int'(found), 1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (uf_now()) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
        found = 1'b1;
      end else begin
        idle(1, 1'b0);
      end
    end
    chk("ack_collision_reached", int'(found), 1);
    idle(20, 1'b0);

    // Random mix of small reloads, strobes, acks and readback selects.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
      cyc(1'b1, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
          1'($urandom), $urandom_range(0, 3) == 0, d);
    end

    // Full-range prescaler, then reset mid-period.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    idle(1500, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
    idle(10, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
